conv33_window_sched: RTL and testbench

CONV33_WINDOW_SCHED -- requirements
Module: conv33_window_sched

---
 rtl/conv33_window_sched_if.sv | 33 +++
 rtl/conv33_window_sched.sv | 131 +++++++++++++
 tb/tb_conv33_window_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv33_window_sched_if.sv
// Handshake and control bundle between the 3x3 window scheduler and its surroundings.
// master = scheduler side, slave = launcher / window datapath / conv core side.
interface conv33_window_sched_if #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned CH_NUM = 1
);
  localparam int unsigned ROW_W = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int unsigned COL_W = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic             win_req_valid;
  logic             win_req_ready;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic [CH_W-1:0]  win_ch;
  logic             win_last;
  logic             res_valid;
  logic             err_unexp;

  modport master (
    input  start, win_req_ready, res_valid,
    output busy, done, win_req_valid, win_row, win_col, win_ch, win_last, err_unexp
  );

  modport slave (
    output start, win_req_ready, res_valid,
    input  busy, done, win_req_valid, win_row, win_col, win_ch, win_last, err_unexp
  );
endinterface

// File: rtl/conv33_window_sched.sv
// Walks every valid 3x3 window (channel, row, col) of a feature map, issuing one
// request per handshake while bounding the number of results still outstanding.
module conv33_window_sched #(
  parameter int unsigned IMG_W   = 28,
  parameter int unsigned IMG_H   = 28,
  parameter int unsigned CH_NUM  = 1,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  conv33_window_sched_if.master  bus
);
  localparam int unsigned ROW_W = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int unsigned COL_W = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 3);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 3);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; registered outputs are derived from the next-state values so the
  // request stays stable while stalled and streams back-to-back when ready.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hs      = valid_q && bus.win_req_ready;

    if (hs && !bus.res_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!hs && bus.res_valid) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end

    if (hs) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN:   if (hs && last_q) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_RUN) && (cnt_d < CNT_MAX);
    last_d  = (row_d == ROW_LAST) && (col_d == COL_LAST) && (ch_d == CH_LAST);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.win_req_valid = valid_q;
  assign bus.win_row       = row_q;
  assign bus.win_col       = col_q;
  assign bus.win_ch        = ch_q;
  assign bus.win_last      = valid_q && last_q;
  assign bus.err_unexp     = err_q;
endmodule

// File: tb/tb_conv33_window_sched.sv
// Randomized bench for conv33_window_sched: a counting model of the pass (issued
// windows, outstanding results) predicts every output each cycle.
module tb_conv33_window_sched;
  localparam int W     = 5;
  localparam int H     = 5;
  localparam int C     = 2;
  localparam int M     = 4;
  localparam int PER   = (H - 2) * (W - 2);
  localparam int TOTAL = PER * C;
  localparam int LAST_CODE = (C - 1) * 100 + (H - 3) * 10 + (W - 3);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv33_window_sched_if #(.IMG_W(W), .IMG_H(H), .CH_NUM(C)) bus ();

  conv33_window_sched #(.IMG_W(W), .IMG_H(H), .CH_NUM(C), .MAX_OUT(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model of the pass: windows issued so far and results still owed.
  bit m_active, m_in_done, m_err;
  int m_issued, m_outst;
  int due_q[$];

  bit start_pending, extra_rv, release_one, withhold, rand_ready, rand_rv;
  int hs_count, done_count, last_count, pass_base;
  int hs_log[$];
  bit ev_c;
  int k_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_valid();
    return m_active && !m_in_done && (m_issued < TOTAL) && (m_outst < M);
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_in_done = 1'b0; m_err = 1'b0;
    m_issued = 0;    m_outst = 0;
    due_q.delete();
  endtask

  // Advance the model by the cycle whose inputs the DUT just sampled.
  task automatic model_update();
    bit hs, was_active;
    if (!rst) begin
      model_reset();
      return;
    end
    was_active = m_active;
    hs = model_valid() && bus.win_req_ready;
    if (m_in_done) begin
      m_active  = 1'b0;
      m_in_done = 1'b0;
    end else if (m_active && m_issued == TOTAL && m_outst == 0) begin
      m_in_done = 1'b1;
    end
    if (hs && !bus.res_valid) m_outst++;
    else if (!hs && bus.res_valid) begin
      if (m_outst == 0) m_err = 1'b1;
      else m_outst--;
    end
    if (hs) begin
      m_issued++;
      due_q.push_back(cyc + 2);
    end
    if (!was_active && bus.start) begin
      m_active = 1'b1; m_issued = 0; m_outst = 0; m_err = 1'b0;
    end
  endtask

  task automatic drive();
    logic rv;
    bus.start     = start_pending;
    start_pending = 1'b0;
    bus.win_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    rv = 1'b0;
    if (extra_rv) begin
      rv = 1'b1;
      extra_rv = 1'b0;
    end else if (release_one && due_q.size() > 0) begin
      rv = 1'b1;
      release_one = 1'b0;
      void'(due_q.pop_front());
    end else if (!withhold && due_q.size() > 0 && due_q[0] <= cyc &&
                 (!rand_rv || $urandom_range(0, 2) != 0)) begin
      rv = 1'b1;
      void'(due_q.pop_front());
    end
    bus.res_valid = rv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    cyc++;
    drive();
  endtask

  // Per-cycle comparison against the model, plus handshake bookkeeping.
  always @(negedge clk) begin
    if (rst) begin
      ev_c = model_valid();
      check("busy",      32'(bus.busy),          32'(m_active));
      check("done",      32'(bus.done),          32'(m_in_done));
      check("req_valid", 32'(bus.win_req_valid), 32'(ev_c));
      check("err_unexp", 32'(bus.err_unexp),     32'(m_err));
      if (ev_c) begin
        k_c = m_issued;
        check("win_ch",   32'(bus.win_ch),   32'(k_c / PER));
        check("win_row",  32'(bus.win_row),  32'((k_c % PER) / (W - 2)));
        check("win_col",  32'(bus.win_col),  32'(k_c % (W - 2)));
        check("win_last", 32'(bus.win_last), 32'(k_c == TOTAL - 1));
      end
      if (bus.win_req_valid && bus.win_req_ready) begin
        hs_count++;
        hs_log.push_back(int'(bus.win_ch) * 100 + int'(bus.win_row) * 10 + int'(bus.win_col));
        if (bus.win_last) last_count++;
      end
      if (bus.done) done_count++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),          0);
    check({tag, "_done"},  32'(bus.done),          0);
    check({tag, "_valid"}, 32'(bus.win_req_valid), 0);
    check({tag, "_last"},  32'(bus.win_last),      0);
    check({tag, "_err"},   32'(bus.err_unexp),     0);
    check({tag, "_row"},   32'(bus.win_row),       0);
    check({tag, "_col"},   32'(bus.win_col),       0);
    check({tag, "_ch"},    32'(bus.win_ch),        0);
  endtask

  // Runs until one done pulse (optionally launching and injecting a stray start).
  task automatic run_pass(input int budget, input int inject_at, input bit do_start);
    int  d0 = done_count;
    int  l0 = last_count;
    int  n  = 0;
    bit  inj = 1'b0;
    if (do_start) begin
      pass_base     = hs_count;
      start_pending = 1'b1;
    end
    while (done_count == d0 && n < budget) begin
      tick();
      n++;
      if (inject_at >= 0 && !inj && hs_count - pass_base >= inject_at) begin
        start_pending = 1'b1;
        inj = 1'b1;
      end
    end
    check("pass_done_pulses", 32'(done_count - d0), 1);
    check("pass_windows", 32'(hs_count - pass_base), 32'(TOTAL));
    check("pass_last_flags", 32'(last_count - (do_start ? l0 : l0)), 1);
    if (hs_log.size() >= pass_base + TOTAL) begin
      check("first_window", 32'(hs_log[pass_base]), 0);
      check("final_window", 32'(hs_log[pass_base + TOTAL - 1]), 32'(LAST_CODE));
    end
    check("busy_after_done", 32'(bus.busy), 0);
    repeat (3) tick();
    check("done_single", 32'(done_count - d0), 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.win_req_ready = 1'b0; bus.res_valid = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Ready always high, results two cycles after each request.
    run_pass(300, -1, 1'b1);

    // Results withheld: in-flight cap, then exactly one more after one release.
    withhold = 1'b1;
    pass_base = hs_count;
    start_pending = 1'b1;
    repeat (20) tick();
    check("cap_windows", 32'(hs_count - pass_base), 32'(M));
    check("cap_valid_low", 32'(bus.win_req_valid), 0);
    release_one = 1'b1;
    repeat (10) tick();
    check("cap_after_release", 32'(hs_count - pass_base), 32'(M + 1));
    withhold = 1'b0;
    run_pass(300, -1, 1'b0);

    // Random ready and random result latency.
    rand_ready = 1'b1; rand_rv = 1'b1;
    run_pass(2000, -1, 1'b1);
    rand_ready = 1'b0; rand_rv = 1'b0;

    // Unexpected result in IDLE: sticky error, cleared by the next start.
    extra_rv = 1'b1;
    repeat (3) tick();
    check("err_set", 32'(bus.err_unexp), 1);
    repeat (4) tick();
    check("err_sticky", 32'(bus.err_unexp), 1);
    run_pass(300, -1, 1'b1);
    check("err_cleared", 32'(bus.err_unexp), 0);

    // Asynchronous reset mid-pass, then a fresh pass from the origin.
    pass_base = hs_count;
    start_pending = 1'b1;
    for (int i = 0; i < 100 && hs_count - pass_base < 7; i++) tick();
    check("pre_reset_windows", 32'(hs_count - pass_base >= 7), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    start_pending = 1'b0; extra_rv = 1'b0; release_one = 1'b0;
    bus.start = 1'b0; bus.res_valid = 1'b0;
    model_reset();
    #1;
    check_all_zero("midpass_reset");
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", 32'(bus.busy), 0);
    run_pass(300, -1, 1'b1);

    // Stray start during RUN is ignored.
    rand_ready = 1'b1;
    run_pass(2000, 5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
